// File: rtl/beat_led_sequencer.sv
// Beat-driven LED pattern sequencer: synchronises the slow beat toggle, advances a
// blink/walk/bounce/count pattern on each transition and PWM-dims the result.
module beat_led_sequencer #(
    parameter int NUM_LEDS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PWM_BITS    = 8,
    localparam int POS_W      = $clog2(NUM_LEDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                beat_i,
    input  logic                enable_i,
    input  logic [1:0]          mode_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                step_o,
    output logic [POS_W-1:0]    pos_o
);

    typedef enum logic [1:0] {
        M_BLINK  = 2'd0,
        M_WALK   = 2'd1,
        M_BOUNCE = 2'd2,
        M_COUNT  = 2'd3
    } mode_e;

    localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] CNT_ONE  = NUM_LEDS'(1);

    // Bits [SYNC_STAGES-1:0] synchronise the beat, the top bit is the history flop.
    logic [SYNC_STAGES:0]  beat_pipe_q;
    logic                  beat_edge;

    mode_e                 mode_q;
    logic                  step_q;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  dir_down_q, dir_down_d;
    logic                  phase_q, phase_d;
    logic [NUM_LEDS-1:0]   cnt_q, cnt_d;
    logic [PWM_BITS-1:0]   pwm_q, duty_q;
    logic [NUM_LEDS-1:0]   led_q;
    logic [NUM_LEDS-1:0]   pat;
    logic                  mode_chg;
    logic                  led_on;

    assign beat_edge = beat_pipe_q[SYNC_STAGES] ^ beat_pipe_q[SYNC_STAGES-1];
    assign mode_chg  = (mode_i != mode_q);
    assign led_on    = enable_i & (pwm_q < duty_q);

    always_comb begin
        pos_d      = pos_q;
        dir_down_d = dir_down_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        if (mode_chg) begin
            // A beat landing on a mode change is still reported but never applied.
            pos_d      = '0;
            dir_down_d = 1'b0;
            phase_d    = 1'b0;
            cnt_d      = '0;
        end else if (enable_i && beat_edge) begin
            case (mode_q)
                M_BLINK:  phase_d = ~phase_q;
                M_WALK:   pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
                M_BOUNCE: begin
                    if (!dir_down_q) begin
                        pos_d = pos_q + POS_ONE;
                        if (pos_q == POS_LAST - POS_ONE) dir_down_d = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                        if (pos_q == POS_ONE) dir_down_d = 1'b0;
                    end
                end
                M_COUNT: begin
                    cnt_d = cnt_q + CNT_ONE;
                    pos_d = cnt_d[POS_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pat = '0;
        case (mode_q)
            M_BLINK:           pat = {NUM_LEDS{phase_q}};
            M_WALK, M_BOUNCE:  pat = CNT_ONE << pos_q;
            M_COUNT:           pat = cnt_q;
            default:           pat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_pipe_q <= '0;
            mode_q      <= M_BLINK;
            step_q      <= 1'b0;
            pos_q       <= '0;
            dir_down_q  <= 1'b0;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            duty_q      <= '0;
            led_q       <= '0;
        end else begin
            beat_pipe_q <= {beat_pipe_q[SYNC_STAGES-1:0], beat_i};
            mode_q      <= mode_e'(mode_i);
            step_q      <= beat_edge;
            pos_q       <= pos_d;
            dir_down_q  <= dir_down_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_q + PWM_BITS'(1);
            // Duty only changes at the period boundary so a period is never split.
            if (&pwm_q) duty_q <= duty_i;
            led_q       <= {NUM_LEDS{led_on}} & pat;
        end
    end

    assign led_o  = led_q;
    assign step_o = step_q;
    assign pos_o  = pos_q;

endmodule

// File: tb/tb_beat_led_sequencer.sv
// Bench for beat_led_sequencer: two instances (8 LEDs/2 sync, 4 LEDs/3 sync) checked
// every cycle against a step-count model, plus a directed table and corner sequences.
module tb_beat_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       beat = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] duty = 8'd0;

    logic [7:0] led8;  logic step8;  logic [2:0] pos8;
    logic [3:0] led4;  logic step4;  logic [1:0] pos4;

    always #5 clk = ~clk;

    beat_led_sequencer #(.NUM_LEDS(8), .SYNC_STAGES(2), .PWM_BITS(8)) u8 (
        .clk(clk), .rst_n(rst_n), .beat_i(beat), .enable_i(enable), .mode_i(mode),
        .duty_i(duty), .led_o(led8), .step_o(step8), .pos_o(pos8));

    beat_led_sequencer #(.NUM_LEDS(4), .SYNC_STAGES(3), .PWM_BITS(8)) u4 (
        .clk(clk), .rst_n(rst_n), .beat_i(beat), .enable_i(enable), .mode_i(mode),
        .duty_i(duty), .led_o(led4), .step_o(step4), .pos_o(pos4));

    int total = 0;
    int bad   = 0;

    // Model: each instance is summarised by the number of applied beats since the
    // last mode change; pattern and position follow arithmetically from that count.
    int         k;
    bit         bh[$];
    int         adv[2];
    logic [1:0] pm;
    int         dq;

    function automatic logic [31:0] mask(int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic int bpos(int n, int a);
        int p, r;
        p = 2 * n - 2;
        r = a % p;
        return (r < n) ? r : p - r;
    endfunction

    function automatic logic [31:0] patf(int n, logic [1:0] m, int a);
        case (m)
            2'd0:    return (a % 2 == 1) ? mask(n) : 32'd0;
            2'd1:    return 32'd1 << (a % n);
            2'd2:    return 32'd1 << bpos(n, a);
            default: return 32'(a) & mask(n);
        endcase
    endfunction

    function automatic int posf(int n, int pw, logic [1:0] m, int a);
        case (m)
            2'd0:    return 0;
            2'd1:    return a % n;
            2'd2:    return bpos(n, a);
            default: return a % (1 << pw);
        endcase
    endfunction

    function automatic bit bget(int j);
        if (j < 0) return 1'b0;
        return bh[j];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        int ss, n, pw, pwm;
        logic [31:0] lx[2], px[2], sx[2];
        @(posedge clk);
        bh.push_back(beat);
        pwm = k % 256;
        for (int d = 0; d < 2; d++) begin
            ss = (d == 0) ? 2 : 3;
            n  = (d == 0) ? 8 : 4;
            pw = (d == 0) ? 3 : 2;
            sx[d] = {31'd0, bget(k - ss) ^ bget(k - ss - 1)};
            lx[d] = (enable && pwm < dq) ? patf(n, pm, adv[d]) : 32'd0;
            if (mode != pm)                adv[d] = 0;
            else if (enable && sx[d][0])   adv[d]++;
            px[d] = 32'(posf(n, pw, mode, adv[d]));
        end
        if (pwm == 255) dq = int'(duty);
        pm = mode;
        k++;
        #1;
        check("led8",  {24'd0, led8},  lx[0]);
        check("step8", {31'd0, step8}, sx[0]);
        check("pos8",  {29'd0, pos8},  px[0]);
        check("led4",  {28'd0, led4},  lx[1]);
        check("step4", {31'd0, step4}, sx[1]);
        check("pos4",  {30'd0, pos4},  px[1]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_led8",  {24'd0, led8},  32'd0);
        check("rst_step8", {31'd0, step8}, 32'd0);
        check("rst_pos8",  {29'd0, pos8},  32'd0);
        check("rst_led4",  {28'd0, led4},  32'd0);
        check("rst_step4", {31'd0, step4}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        bh.delete();
        adv = '{0, 0};
        pm = 2'd0;
        dq = 0;
    endtask

    task automatic toggles(int n);
        for (int t = 0; t < n; t++) begin
            beat = ~beat;
            repeat (10) tick();
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        bit         en;
        int         tog;
        int         p8;
        int         p4;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int hi;

        tbl[0] = '{mode: 2'd1, en: 1'b1, tog: 9,  p8: 1, p4: 1};
        tbl[1] = '{mode: 2'd2, en: 1'b1, tog: 16, p8: 2, p4: 2};
        tbl[2] = '{mode: 2'd3, en: 1'b1, tog: 17, p8: 1, p4: 1};
        tbl[3] = '{mode: 2'd1, en: 1'b1, tog: 5,  p8: 5, p4: 1};
        tbl[4] = '{mode: 2'd1, en: 1'b0, tog: 3,  p8: 5, p4: 1};
        tbl[5] = '{mode: 2'd1, en: 1'b1, tog: 1,  p8: 6, p4: 2};
        tbl[6] = '{mode: 2'd0, en: 1'b1, tog: 1,  p8: 0, p4: 0};

        #2;
        do_reset();
        mode = 2'd1; enable = 1'b1; duty = 8'd255;

        for (int r = 0; r < 7; r++) begin
            mode   = tbl[r].mode;
            enable = tbl[r].en;
            repeat (3) tick();
            toggles(tbl[r].tog);
            check("tbl_pos8", {29'd0, pos8}, 32'(tbl[r].p8));
            check("tbl_pos4", {30'd0, pos4}, 32'(tbl[r].p4));
        end

        // PWM: blink phase is now 1 (all ones); duty switch mid-period waits a period.
        duty = 8'd64;
        repeat (300) tick();
        while (k % 256 != 0) tick();
        hi = 0;
        for (int i = 0; i < 256; i++) begin tick(); hi += int'(led8[0]); end
        check("pwm_duty64", 32'(hi), 32'd64);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) duty = 8'd128;
            tick();
            hi += int'(led8[0]);
        end
        check("pwm_midchange", 32'(hi), 32'd64);
        hi = 0;
        for (int i = 0; i < 256; i++) begin tick(); hi += int'(led8[0]); end
        check("pwm_duty128", 32'(hi), 32'd128);

        // Mode change on the very cycle the 8-LED instance applies a beat.
        mode = 2'd1;
        repeat (3) tick();
        toggles(3);
        check("pre_coinc_pos8", {29'd0, pos8}, 32'd3);
        beat = ~beat;
        tick();
        tick();
        mode = 2'd2;
        tick();
        check("coinc_step8", {31'd0, step8}, 32'd1);
        check("coinc_pos8",  {29'd0, pos8},  32'd0);
        repeat (10) tick();
        toggles(1);
        check("coinc_next_pos8", {29'd0, pos8}, 32'd1);

        // Random traffic, including fast beat toggles and enable/mode churn.
        duty = 8'd200;
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)   beat = ~beat;
            if ($urandom_range(199) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(99) == 0)  enable = ($urandom_range(3) != 0);
            if ($urandom_range(299) == 0) duty = 8'($urandom_range(255));
            tick();
        end

        // Async reset landing right on a step pulse with LEDs lit.
        mode = 2'd1; enable = 1'b1; duty = 8'd255;
        repeat (520) tick();
        beat = ~beat;
        repeat (3) tick();
        check("pre_rst_step8", {31'd0, step8}, 32'd1);
        do_reset();
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_led_sequencer.md
Name: beat_led_sequencer

Overview:
- Downstream consumer of the board's slow beat toggle (the 1 Hz blink output).
- Each beat transition advances an LED pattern: blink, walking one, bounce, or binary count.
- Active LEDs are brightness-modulated by a free-running PWM.
- Sits between the beat generator and the board LED pins.

Parameters:
NUM_LEDS, 8, number of LED outputs; legal range 2..32
SYNC_STAGES, 2, synchroniser depth on beat input; legal range 2..4
PWM_BITS, 8, PWM counter and duty width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
beat  input  1  slow toggle from beat generator; treated as asynchronous
enable  input  1  1 = pattern runs and LEDs driven; 0 = LEDs dark, state frozen
mode  input  2  0 BLINK, 1 WALK, 2 BOUNCE, 3 COUNT
duty  input  PWM_BITS  LED on-time per PWM period, in clk cycles
led  output  NUM_LEDS  registered LED drive
step  output  1  one-cycle pulse per detected beat transition
pos  output  POS_W  current position, POS_W = clog2(NUM_LEDS); in COUNT mode, low bits of counter

Behaviour:
- Reset (rst_n=0, async): every flop cleared. led=0, step=0, pos=0, dir=up, phase=0, cnt=0, pwm_cnt=0, duty_q=0, mode_q=0. Deassertion is used as-is; no internal reset synchroniser.
- Edge detect:
  - beat passes through SYNC_STAGES flops, then one history flop.
  - edge = sync_out XOR history; both rising and falling transitions count.
  - Transition captured at edge 0: step=1 for exactly one cycle after edge SYNC_STAGES.
  - Pattern state advances at that same edge.
- Mode-change handling:
  - mode_q registers mode every cycle.
  - When mode != mode_q: pos=0, dir=up, phase=0, cnt=0 at next edge.
  - A step coinciding with a mode change is reported on step but does not advance state.
- Advance rules (only when enable=1, step fires, and no mode change):
  - BLINK: phase toggles; pat = all ones if phase=1, else all zeros.
  - WALK: pos = (pos+1) mod NUM_LEDS; pat = one-hot at pos. Wraps NUM_LEDS-1 -> 0.
  - BOUNCE:
    - If dir=up and pos=NUM_LEDS-2: pos becomes NUM_LEDS-1 and dir flips to down.
    - If dir=down and pos=1: pos becomes 0 and dir flips to up.
    - Otherwise pos steps by dir.
    - Sequence 0,1,..,N-1,N-2,..,1,0,1..; endpoints are never held two steps. pat = one-hot at pos.
  - COUNT: cnt = (cnt+1) mod 2^NUM_LEDS; pat = cnt; pos = cnt[POS_W-1:0].
- pat is combinational from state. Pattern is visible on led one cycle after the state update, subject to PWM.
- enable=0:
  - led=0 at next edge; pos/dir/phase/cnt frozen.
  - step keeps pulsing; PWM keeps running.
  - On re-enable, resumes from frozen state. Mode-change reset still applies while disabled.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_BITS-1 and wraps to 0.
  - duty_q loads duty only on the cycle pwm_cnt wraps to 0, so there are no mid-period glitches.
  - led[i] <= enable & pat[i] & (pwm_cnt < duty_q).
  - duty=0: always dark. duty=2^PWM_BITS-1: on 255 of 256 cycles (PWM_BITS=8); full-on is not reachable by design.
- Async reset mid-pattern: outputs drop to 0 immediately, without waiting for a clock edge.
- beat toggling faster than SYNC_STAGES+1 cycles is not required to be resolved; any pulse that survives synchronisation produces exactly one step.

Test Plan:
- Reset, then mode=1, enable=1, duty=255, NUM_LEDS=8; toggle beat 9 times, >=10 clk apart -> 9 step pulses, each 1 cycle, SYNC_STAGES cycles after the beat change; pos 1,2,..,7,0,1; led one-hot matches pos during PWM on-time.
- mode=2; 16 beat toggles -> pos 1..7,6,..,0,1,2; dir flips exactly at pos 7 and pos 0.
- mode=3, NUM_LEDS=4; 17 toggles -> cnt wraps 15 -> 0 at toggle 16, ends at 1; led pattern equals cnt while PWM on.
- duty=64 with pattern all-ones (mode 0, phase=1) -> each led high exactly 64 of every 256 cycles; duty changed to 128 mid-period takes effect only from next pwm_cnt=0.
- At pos=5 in WALK, drop enable for 3 toggles -> led=0 next cycle, step still pulses, pos stays 5; re-enable, one toggle -> pos=6.
- Change mode 1->2 on the same cycle a step fires -> step=1, pos=0 and dir=up next cycle, no advance; also assert rst_n=0 mid-run -> led=0 and step=0 immediately.
